// File: rtl/wb_traffic_gen.sv
// rtl/wb_traffic_gen.sv - Self-checking Wishbone B3 burst write/read-back traffic generator
//
// Sole bus master of the memory-subsystem test harness. Each transaction writes a
// pseudo-random burst (linear or wrap4/8/16) into the test window, then reads the
// same beats back and compares the selected bytes against regenerated data.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, synchronous active-low reset
//   wb_adr_o/dat_o/sel_o     byte address (word aligned), write data, byte select
//   wb_we_o/cyc_o/stb_o      Wishbone master controls
//   wb_cti_o/bte_o           burst cycle type / burst type extension
//   wb_dat_i/ack_i/err_i/rty_i  slave read data and terminations
//   done                     sequence finished (sticky)
//   fail                     any mismatch, bus error or timeout (sticky)
//   mis_cnt, bus_err_cnt     saturating error counters
//   fail_adr                 address of the first failing beat
module wb_traffic_gen #(
    parameter int          aw            = 32,
    parameter int          dw            = 32,
    parameter int          MAX_BURST_LEN = 32,
    parameter logic [31:0] MEM_LOW       = 32'h0,
    parameter int          MEM_WORDS     = 1024,
    parameter int          TRANSACTIONS  = 1000,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] SEED          = 32'h1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    output logic            done,
    output logic            fail,
    output logic [15:0]     mis_cnt,
    output logic [15:0]     bus_err_cnt,
    output logic [aw-1:0]   fail_adr
);
    localparam int BW = dw / 8;
    localparam int WW = $clog2(MEM_WORDS);
    localparam int LW = $clog2(MAX_BURST_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int XW = $clog2(TRANSACTIONS + 2);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WRITE, S_GAP, S_READ, S_NEXT, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    ctl_lfsr, dat_lfsr, saved_lfsr;
    logic [WW-1:0]  start_r;
    logic [LW-1:0]  len_r, beat_r;
    logic [1:0]     type_r;
    logic [BW-1:0]  sel_r;
    logic           rty_gap;
    logic [TW-1:0]  tmo_cnt;
    logic [XW-1:0]  tx_cnt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Burst parameters decoded from the control LFSR, latched in SETUP.
    logic [31:0]   lin_len32, start32, len32;
    logic [1:0]    s_type;
    logic [BW-1:0] s_sel;

    always_comb begin
        s_type    = ctl_lfsr[1:0];
        lin_len32 = (32'(ctl_lfsr[15:8]) & 32'(MAX_BURST_LEN - 1)) + 32'd1;
        start32   = 32'(ctl_lfsr[31:16]) & 32'(MEM_WORDS - 1);
        if (s_type == 2'd0) begin
            len32 = lin_len32;
            // Pull a linear burst back so it never runs off the window end.
            if (start32 + len32 > 32'(MEM_WORDS)) begin
                start32 = 32'(MEM_WORDS) - len32;
            end
        end else begin
            len32 = 32'd2 << s_type;
        end
        s_sel = BW'(ctl_lfsr[7:4]);
        if (s_sel == '0) begin
            s_sel = '1;
        end
    end

    // Data pattern (replicated or truncated to dw) and the byte-lane compare mask.
    logic [dw-1:0] gen_data, byte_mask;

    always_comb begin
        gen_data  = '0;
        byte_mask = '0;
        for (int i = 0; i < dw; i++) begin
            gen_data[i]  = dat_lfsr[i % 32];
            byte_mask[i] = sel_r[i / 8];
        end
    end

    // A linear burst uses an all-ones mask so the same expression covers both kinds.
    logic [WW-1:0] wrap_mask, cur_word;
    logic [aw-1:0] cur_adr;

    assign wrap_mask = (type_r == 2'd0) ? '1 : WW'(len_r - LW'(1));
    assign cur_word  = (start_r & ~wrap_mask) | ((start_r + WW'(beat_r)) & wrap_mask);
    assign cur_adr   = aw'(MEM_LOW) + aw'(cur_word) * aw'(BW);

    logic bus_act, beat_last, beat_ack, tmo_hit, abort, rd_mismatch;

    assign beat_last   = (beat_r == len_r - LW'(1));
    assign beat_ack    = bus_act && wb_ack_i && !wb_err_i;
    assign tmo_hit     = !wb_ack_i && !wb_rty_i && (tmo_cnt == TW'(TIMEOUT - 1));
    assign abort       = bus_act && (wb_err_i || tmo_hit);
    assign rd_mismatch = ((wb_dat_i ^ gen_data) & byte_mask) != '0;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = (TRANSACTIONS == 0) ? S_DONE : S_SETUP;
            S_SETUP: state_nxt = S_WRITE;
            S_WRITE: begin
                if (abort) begin
                    state_nxt = S_NEXT;
                end else if (beat_ack && beat_last) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = S_READ;
            S_READ: begin
                if (abort || (beat_ack && beat_last)) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT:  state_nxt = (32'(tx_cnt) + 32'd1 == 32'(TRANSACTIONS)) ? S_DONE : S_SETUP;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; rty_gap is the one-cycle bus release that follows a retry.
    always_comb begin
        bus_act  = ((state == S_WRITE) || (state == S_READ)) && !rty_gap;
        wb_cyc_o = bus_act;
        wb_stb_o = bus_act;
        wb_we_o  = bus_act && (state == S_WRITE);
        wb_adr_o = bus_act ? cur_adr : '0;
        wb_dat_o = wb_we_o ? gen_data : '0;
        wb_sel_o = bus_act ? sel_r : '0;
        wb_bte_o = bus_act ? type_r : 2'b00;
        wb_cti_o = 3'b000;
        if (bus_act && len_r != LW'(1)) begin
            wb_cti_o = beat_last ? 3'b111 : 3'b010;
        end
        done = (state == S_DONE);
    end

    // Datapath: burst latch, beat progress, LFSRs and error bookkeeping
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ctl_lfsr    <= SEED;
            dat_lfsr    <= SEED;
            saved_lfsr  <= SEED;
            start_r     <= '0;
            len_r       <= '0;
            type_r      <= '0;
            sel_r       <= '0;
            beat_r      <= '0;
            rty_gap     <= 1'b0;
            tmo_cnt     <= '0;
            tx_cnt      <= '0;
            fail        <= 1'b0;
            mis_cnt     <= '0;
            bus_err_cnt <= '0;
            fail_adr    <= '0;
        end else begin
            case (state)
                S_SETUP: begin
                    start_r    <= WW'(start32);
                    len_r      <= LW'(len32);
                    type_r     <= s_type;
                    sel_r      <= s_sel;
                    saved_lfsr <= dat_lfsr;
                    ctl_lfsr   <= lfsr_step(ctl_lfsr);
                    beat_r     <= '0;
                    rty_gap    <= 1'b0;
                    tmo_cnt    <= '0;
                end
                S_WRITE, S_READ: begin
                    if (rty_gap) begin
                        rty_gap <= 1'b0;
                        tmo_cnt <= '0;
                    end else if (abort) begin
                        bus_err_cnt <= sat_inc(bus_err_cnt);
                        fail        <= 1'b1;
                        if (!fail) begin
                            fail_adr <= cur_adr;
                        end
                    end else if (beat_ack) begin
                        dat_lfsr <= lfsr_step(dat_lfsr);
                        beat_r   <= beat_r + LW'(1);
                        tmo_cnt  <= '0;
                        if (state == S_READ && rd_mismatch) begin
                            mis_cnt <= sat_inc(mis_cnt);
                            fail    <= 1'b1;
                            if (!fail) begin
                                fail_adr <= cur_adr;
                            end
                        end
                    end else if (wb_rty_i) begin
                        rty_gap <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    // Rewind so the read phase regenerates the written data.
                    dat_lfsr <= saved_lfsr;
                    beat_r   <= '0;
                    tmo_cnt  <= '0;
                end
                S_NEXT: tx_cnt <= tx_cnt + XW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/wb_traffic_gen.md
# wb_traffic_gen

Synthesizable, self-checking Wishbone B3 burst traffic generator. It replaces the simulation-only transactor and BFM pair with RTL that runs on FPGA as well as in simulation. Each transaction is a random-length write burst into a memory window, followed by a read-back of the same beats with byte-masked comparison. It sits at the top of the memory-subsystem test harness as the sole bus master and reports pass/fail, error counters and first-failure address.

## Interface
- aw, 32, address width (byte address)
- dw, 32, data width; one of 8/16/32/64
- MAX_BURST_LEN, 32, power of two, ≥16
- MEM_LOW, 0, byte base of test window; aligned to 16 words
- MEM_WORDS, 1024, window size in words; power of two, ≥MAX_BURST_LEN
- TRANSACTIONS, 1000, write+read pairs to run; 0 means no bus activity
- TIMEOUT, 255, max cycles a beat waits for ack/err/rty
- SEED, 32'h1, initial LFSR state; nonzero

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  synchronous, active-low reset
- wb_adr_o  out  aw  byte address, word aligned
- wb_dat_o  out  dw  write data
- wb_sel_o  out  dw/8  byte select
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each
- wb_cti_o  out  3; wb_bte_o  out  2
- wb_dat_i  in  dw; wb_ack_i, wb_err_i, wb_rty_i  in  1 each
- done  out  1  sequence finished, sticky
- fail  out  1  any mismatch, bus error or timeout, sticky
- mis_cnt  out  16  read-data mismatches, saturating
- bus_err_cnt  out  16  err_i plus timeouts, saturating
- fail_adr  out  aw  address of first failing beat

## Operation
- FSM states: IDLE → SETUP → WRITE → GAP → READ → NEXT → (SETUP | DONE).
- Control LFSR (32-bit Galois, taps 0x80200003):
  - Advances once per SETUP.
  - Fields: type = bits[1:0], where 0 = linear, 1 = wrap4, 2 = wrap8, 3 = wrap16.
  - Linear length = (bits[15:8] & (MAX_BURST_LEN−1)) + 1.
  - sel = bits[7:4] (low dw/8 bits); forced to all-ones if zero.
  - Start word = bits[31:16] & (MEM_WORDS−1).
- Address rules:
  - Linear: if start + len > MEM_WORDS, then start = MEM_WORDS − len.
  - Wrap-N: len = N; address increments modulo N within the N-aligned block.
  - Output address = MEM_LOW + word × dw/8.
- SETUP latches start, len, type and sel, and saves the data LFSR state.
- WRITE:
  - wb_dat_o = data LFSR (same polynomial), replicated to dw for dw>32 or truncated for dw<32.
  - The data LFSR advances on each ack.
- READ:
  - Data LFSR is restored from the saved state and regenerates the expected data.
  - On each ack, selected bytes are compared.
  - On mismatch: mis_cnt++, fail=1, and fail_adr is captured if this is the first failure.
- Bus signalling:
  - cti = 010 for all but the last beat, 111 on the last; a len=1 linear burst uses cti = 000.
  - bte = 00 for linear, 01/10/11 for wrap4/8/16.
  - cyc and stb are both high for the whole burst; we = 1 only in WRITE.
- Termination:
  - ack: advance to the next beat.
  - rty: drop cyc/stb for exactly one cycle, then reissue the same beat with the same address and data.
  - err or timeout: bus_err_cnt++, fail=1, burst aborted. If in WRITE, skip READ and go to NEXT.
  - Simultaneous ack+err is treated as err; ack+rty is treated as ack.
- NEXT increments the transaction counter. DONE holds the bus idle and sets done.

## Timing
- Reset (wb_rst_ni low at a clock edge):
  - All outputs go to 0 on the next edge; LFSRs load SEED; counters clear.
  - Reset mid-burst drops cyc immediately with no completion.
  - After release, the sequence replays identically.
- First stb rises 2 cycles after reset release (IDLE, SETUP).
- Zero-wait slave:
  - One beat per cycle.
  - GAP holds cyc low for exactly 1 cycle between write and read.
  - NEXT plus SETUP is 2 idle cycles between transactions.
- Timeout counter:
  - Resets on every new beat and on rty.
  - Abort fires when the count reaches TIMEOUT; cyc drops on the next edge.
- Counters saturate at 16'hFFFF. fail and done clear only on reset.

## Test plan
- Zero-wait RAM model, TRANSACTIONS=8 → done=1, fail=0, mis_cnt=0, bus_err_cnt=0, and the number of ack cycles equals twice the sum of burst lengths.
- Force control LFSR to a wrap4, start word 6, dw=32, MEM_LOW=0 → adr 0x18, 0x1C, 0x10, 0x14; cti 010, 010, 010, 111; bte 01; read phase repeats the same sequence.
- RAM flips bit 0 of the read data at word 5 once → mis_cnt=1, fail=1, fail_adr=MEM_LOW+0x14, done still reached.
- Slave asserts err on write beat 2 → cyc low next cycle, no read burst for that transaction, bus_err_cnt=1, next transaction proceeds.
- Slave never responds, TIMEOUT=16 → cyc drops 16 cycles after the first stb, bus_err_cnt increments per transaction, done=1 after TRANSACTIONS timeouts.
- rty on beat 0, then reset pulled low mid-burst → one-cycle cyc gap and the beat reissued with the same address; after reset all outputs are 0 and the first transaction's address and data are bit-identical to the original run.
